// File: rtl/amf_scan_if.sv
// Bus between the frame-scan controller and its image RAM, filter core and output RAM.
// Handshake: win_valid has no ready, so the core takes every beat; dec_valid is a one-cycle strobe honoured only in WAIT after win_last.
interface amf_scan_if #(
  parameter int AW = 12,
  parameter int DW = 8
) ();
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          win_valid;
  logic [DW-1:0] win_data;
  logic          win_first;
  logic          win_last;
  logic [3:0]    win_size;
  logic          dec_valid;
  logic          dec_grow;
  logic [DW-1:0] dec_pix;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   fb_cnt;
  logic          endF;

  modport master (
    input  start, rd_data, dec_valid, dec_grow, dec_pix,
    output rd_en, rd_addr, win_valid, win_data, win_first, win_last, win_size,
           wr_en, wr_addr, wr_data, fb_cnt, endF
  );

  modport slave (
    output start, rd_data, dec_valid, dec_grow, dec_pix,
    input  rd_en, rd_addr, win_valid, win_data, win_first, win_last, win_size,
           wr_en, wr_addr, wr_data, fb_cnt, endF
  );
endinterface

// File: rtl/amf_scan_ctrl.sv
// Frame-scan controller for the adaptive median filter: walks the image in row-major order,
// streams a clamped square window per pixel, grows it on request and writes each result.
module amf_scan_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SMAX  = 7,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  amf_scan_if.master   bus,
  output logic [2:0]   state_dbg
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [3:0]        size;
  logic signed [4:0] wy;
  logic signed [4:0] wx;
  logic              cen_pend;
  logic [DW-1:0]     cen_pix;

  int                h_i;
  int                wy_i;
  int                wx_i;
  int                nwy_i;
  int                nwx_i;
  int                nxt_row;
  int                nxt_col;
  logic              first_rd;
  logic              last_rd;
  logic              centre_rd;
  logic              last_col;
  logic              last_pix;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     step_addr;
  logic [AW-1:0]     grow_addr;
  logic [AW-1:0]     pix_addr;
  logic [AW-1:0]     next_pix_addr;

  // Window coordinates outside the frame are clamped to the nearest edge pixel.
  function automatic logic [AW-1:0] win_addr(input int r, input int c, input int dy, input int dx);
    int y;
    int x;
    y = r + dy;
    x = c + dx;
    if (y < 0) y = 0;
    else if (y > IMG_H - 1) y = IMG_H - 1;
    if (x < 0) x = 0;
    else if (x > IMG_W - 1) x = IMG_W - 1;
    return AW'(y * IMG_W + x);
  endfunction

  always_comb begin
    h_i       = (int'(size) - 1) / 2;
    wy_i      = int'(wy);
    wx_i      = int'(wx);
    first_rd  = (wy_i == -h_i) && (wx_i == -h_i);
    last_rd   = (wy_i == h_i) && (wx_i == h_i);
    centre_rd = (wy_i == 0) && (wx_i == 0);
    nwy_i     = wy_i;
    nwx_i     = wx_i + 1;
    if (wx_i == h_i) begin
      nwy_i = wy_i + 1;
      nwx_i = -h_i;
    end
    last_col      = (int'(col) == IMG_W - 1);
    last_pix      = last_col && (int'(row) == IMG_H - 1);
    nxt_row       = last_col ? int'(row) + 1 : int'(row);
    nxt_col       = last_col ? 0 : int'(col) + 1;
    start_addr    = win_addr(0, 0, -1, -1);
    step_addr     = win_addr(int'(row), int'(col), nwy_i, nwx_i);
    grow_addr     = win_addr(int'(row), int'(col), -(h_i + 1), -(h_i + 1));
    pix_addr      = win_addr(int'(row), int'(col), 0, 0);
    next_pix_addr = win_addr(nxt_row, nxt_col, -1, -1);
  end

  // Read data arrives one cycle after rd_en, exactly when win_valid is high.
  assign bus.win_data = bus.win_valid ? bus.rd_data : '0;
  assign bus.win_size = size;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      size          <= 4'd3;
      wy            <= '0;
      wx            <= '0;
      cen_pend      <= 1'b0;
      cen_pix       <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.win_valid <= 1'b0;
      bus.win_first <= 1'b0;
      bus.win_last  <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.fb_cnt    <= '0;
      bus.endF      <= 1'b0;
    end else begin
      bus.win_valid <= bus.rd_en;
      bus.win_first <= 1'b0;
      bus.win_last  <= 1'b0;
      bus.wr_en     <= 1'b0;
      cen_pend      <= 1'b0;
      if (cen_pend) cen_pix <= bus.rd_data;

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= READ;
            row         <= '0;
            col         <= '0;
            size        <= 4'd3;
            wy          <= -5'sd1;
            wx          <= -5'sd1;
            bus.endF    <= 1'b0;
            bus.fb_cnt  <= '0;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= start_addr;
          end
        end

        READ: begin
          bus.win_first <= first_rd;
          bus.win_last  <= last_rd;
          cen_pend      <= centre_rd;
          if (last_rd) begin
            bus.rd_en <= 1'b0;
            state     <= WAIT;
          end else begin
            wy          <= 5'(nwy_i);
            wx          <= 5'(nwx_i);
            bus.rd_addr <= step_addr;
          end
        end

        // The win_last cycle is the first WAIT cycle; decisions are taken only after it.
        WAIT: begin
          if (bus.dec_valid && !bus.win_last) begin
            if (!bus.dec_grow) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= pix_addr;
              bus.wr_data <= bus.dec_pix;
              state       <= WRITE;
            end else if (size < 4'(SMAX)) begin
              size        <= size + 4'd2;
              wy          <= 5'(-(h_i + 1));
              wx          <= 5'(-(h_i + 1));
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= grow_addr;
              state       <= READ;
            end else begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= pix_addr;
              bus.wr_data <= cen_pix;
              if (bus.fb_cnt != 16'hFFFF) bus.fb_cnt <= bus.fb_cnt + 16'd1;
              state       <= WRITE;
            end
          end
        end

        WRITE: begin
          size <= 4'd3;
          if (last_pix) begin
            bus.endF <= 1'b1;
            state    <= DONE;
          end else begin
            row         <= RW'(nxt_row);
            col         <= CW'(nxt_col);
            wy          <= -5'sd1;
            wx          <= -5'sd1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= next_pix_addr;
            state       <= READ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
